mem_wb_stage: RTL and testbench

//  Memory-access/writeback stage fed by the execute-to-memory pipeline register (*_d2 signals).

---
 rtl/cpu_pkg.sv | 14 +
 rtl/mem_wb_stage_if.sv | 43 ++++
 rtl/mem_wb_stage_wb_result_mux.sv | 23 ++
 rtl/mem_wb_stage.sv | 116 +++++++++++
 tb/tb_mem_wb_stage.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared opcodes and memory-stage FSM encoding for the CPU pipeline.
package cpu_pkg;

  localparam logic [5:0] OP_LOAD  = 6'h23;
  localparam logic [5:0] OP_STORE = 6'h2B;
  localparam logic [5:0] OP_MUL   = 6'h18;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle of the d2 pipeline inputs, data-memory handshake and writeback port.
// The slave side is the mem/wb stage; the master side is the surrounding pipeline and memory.
interface mem_wb_stage_if #(parameter int DW = 32);

  logic [5:0]    opcode_d2;
  logic [4:0]    rd_d2;
  logic          register_we_d2;
  logic          data_we_d2;
  logic [DW-1:0] reg_rs1_d2;
  logic [DW-1:0] alu_out_d2;
  logic [DW-1:0] sum_d2;
  logic [DW-1:0] multiply_d2;

  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;

  logic          stall;
  logic          wb_we;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic          mem_error;

  modport master (
    output opcode_d2, rd_d2, register_we_d2, data_we_d2,
           reg_rs1_d2, alu_out_d2, sum_d2, multiply_d2,
           dmem_ack, dmem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
           stall, wb_we, wb_rd, wb_data, mem_error
  );

  modport slave (
    input  opcode_d2, rd_d2, register_we_d2, data_we_d2,
           reg_rs1_d2, alu_out_d2, sum_d2, multiply_d2,
           dmem_ack, dmem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
           stall, wb_we, wb_rd, wb_data, mem_error
  );

endinterface

// File: rtl/mem_wb_stage_wb_result_mux.sv
// Opcode-based writeback result select; also reused by the forwarding network.
module wb_result_mux
  import cpu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [5:0]    opcode,
  input  logic [DW-1:0] alu_out,
  input  logic [DW-1:0] sum,
  input  logic [DW-1:0] multiply,
  output logic [DW-1:0] result
);

  always_comb begin
    result = alu_out;
    case (opcode)
      OP_MUL:  result = multiply;
      OP_ADDI: result = sum;
      default: result = alu_out;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: issues loads and stores over a req/ack handshake,
// registers the register-file write and stalls upstream while an access is pending.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no access outstanding; non-mem ops write back next edge
//   ST_WAIT | dmem_req held, waiting for dmem_ack or the timeout count
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic          clock,
  input logic          reset_n,
  mem_wb_stage_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_e    state;
  logic [CW-1:0] wait_cnt;
  logic          req_q;
  logic          we_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          wb_we_q;
  logic [4:0]    wb_rd_q;
  logic [DW-1:0] wb_data_q;
  logic          mem_error_q;

  logic          is_load;
  logic          is_store;
  logic          is_mem;
  logic          rd_writable;
  logic [DW-1:0] result;

  assign is_load     = (bus.opcode_d2 == OP_LOAD);
  assign is_store    = bus.data_we_d2;
  assign is_mem      = is_load | is_store;
  assign rd_writable = bus.register_we_d2 & (bus.rd_d2 != 5'd0);

  wb_result_mux #(.DW(DW)) u_result_mux (
    .opcode   (bus.opcode_d2),
    .alu_out  (bus.alu_out_d2),
    .sum      (bus.sum_d2),
    .multiply (bus.multiply_d2),
    .result   (result)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= '0;
      mem_error_q <= 1'b0;
    end else begin
      wb_we_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (is_mem) begin
            req_q    <= 1'b1;
            we_q     <= is_store;
            addr_q   <= bus.sum_d2;
            wdata_q  <= bus.reg_rs1_d2;
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end else begin
            wb_we_q   <= rd_writable;
            wb_rd_q   <= bus.rd_d2;
            wb_data_q <= result;
          end
        end
        ST_WAIT: begin
          // ack is checked first so a late ack on the last wait cycle still completes
          if (bus.dmem_ack) begin
            req_q <= 1'b0;
            state <= ST_IDLE;
            if (!we_q) begin
              wb_we_q   <= rd_writable;
              wb_rd_q   <= bus.rd_d2;
              wb_data_q <= bus.dmem_rdata;
            end
          end else if (wait_cnt == CNT_LAST) begin
            req_q       <= 1'b0;
            mem_error_q <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Stall drops in the ack cycle so upstream advances on the completing edge.
  assign bus.stall = reset_n & (((state == ST_IDLE) & is_mem) |
                                ((state == ST_WAIT) & ~bus.dmem_ack));

  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.wb_we      = wb_we_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.mem_error  = mem_error_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: writeback scoreboard plus a delayed-ack memory responder.
module tb_mem_wb_stage;
  import cpu_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int          ack_delay = 1;
  bit          mem_no_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  int          req_cnt = 0;

  logic [36:0] exp_q[$];

  mem_wb_stage_if #(.DW(32)) bus ();

  mem_wb_stage #(.DW(32), .TIMEOUT(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [5:0] op, input logic [31:0] alu,
                                            input logic [31:0] sum, input logic [31:0] mul);
    if (op == OP_MUL) return mul;
    if (op == OP_ADDI) return sum;
    return alu;
  endfunction

  task automatic bubble();
    bus.opcode_d2      = 6'h00;
    bus.rd_d2          = 5'd0;
    bus.register_we_d2 = 1'b0;
    bus.data_we_d2     = 1'b0;
  endtask

  // memory responder: ack after ack_delay cycles of req
  always @(posedge clock) begin
    #1;
    bus.dmem_ack = 1'b0;
    if (reset_n && bus.dmem_req) begin
      req_cnt++;
      if (!mem_no_ack && req_cnt == ack_delay) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = mem_rdata;
        req_cnt        = 0;
      end
    end else begin
      req_cnt = 0;
    end
  end

  // writeback scoreboard
  always @(negedge clock) begin
    if (reset_n && bus.wb_we) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'(bus.wb_rd), 32'h0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wb_rd", 32'(bus.wb_rd), 32'(e[36:32]));
        chk("wb_data", bus.wb_data, e[31:0]);
      end
    end
  end

  // mode 0: non-mem, 1: mem with ack, 2: mem expected to time out
  task automatic issue(input logic [5:0] op, input logic [4:0] rd, input logic rwe,
                       input logic dwe, input logic [31:0] rs1, input logic [31:0] alu,
                       input logic [31:0] sum, input logic [31:0] mul,
                       input int mode, input int exp_req);
    int req_cyc;
    bit done;
    bus.opcode_d2      = op;
    bus.rd_d2          = rd;
    bus.register_we_d2 = rwe;
    bus.data_we_d2     = dwe;
    bus.reg_rs1_d2     = rs1;
    bus.alu_out_d2     = alu;
    bus.sum_d2         = sum;
    bus.multiply_d2    = mul;
    if (rwe && rd != 5'd0 && !dwe && mode != 2) begin
      if (op == OP_LOAD) exp_q.push_back({rd, mem_rdata});
      else exp_q.push_back({rd, model_res(op, alu, sum, mul)});
    end
    req_cyc = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (i == 0) chk("stall_first", 32'(bus.stall), 32'(mode != 0));
      if (bus.dmem_req) begin
        req_cyc++;
        chk("dmem_addr", bus.dmem_addr, sum);
        chk("dmem_we", 32'(bus.dmem_we), 32'(dwe));
        chk("dmem_wdata", bus.dmem_wdata, rs1);
      end
      if (mode == 2) begin
        if (req_cyc > 0 && !bus.dmem_req) begin
          done = 1'b1;
          chk("timeout_err", 32'(bus.mem_error), 32'h1);
          chk("timeout_cycles", 32'(req_cyc), 32'(exp_req));
          bubble();
          #1;
          chk("stall_after_to", 32'(bus.stall), 32'h0);
        end
      end else if (!bus.stall) begin
        done = 1'b1;
      end
    end
    if (!done) chk("issue_bound", 32'h0, 32'h1);
    if (mode == 1) chk("req_cycles", 32'(req_cyc), 32'(exp_req));
    @(posedge clock);
    #1;
    bubble();
  endtask

  initial begin
    bubble();
    bus.reg_rs1_d2  = '0;
    bus.alu_out_d2  = '0;
    bus.sum_d2      = '0;
    bus.multiply_d2 = '0;
    bus.dmem_ack    = 1'b0;
    bus.dmem_rdata  = '0;

    repeat (3) @(negedge clock);
    chk("rst_req", 32'(bus.dmem_req), 32'h0);
    chk("rst_we", 32'(bus.dmem_we), 32'h0);
    chk("rst_addr", bus.dmem_addr, 32'h0);
    chk("rst_wdata", bus.dmem_wdata, 32'h0);
    chk("rst_wb_we", 32'(bus.wb_we), 32'h0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'h0);
    chk("rst_wb_data", bus.wb_data, 32'h0);
    chk("rst_err", 32'(bus.mem_error), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // ALU, MUL, ADDI selection
    issue(6'h00, 5'd5, 1'b1, 1'b0, 32'h0, 32'h1234, 32'h9, 32'h77, 0, 0);
    issue(OP_MUL, 5'd6, 1'b1, 1'b0, 32'h0, 32'h1, 32'h2, 32'd42, 0, 0);
    issue(OP_ADDI, 5'd7, 1'b1, 1'b0, 32'h0, 32'h3, 32'd7, 32'h4, 0, 0);
    for (int k = 0; k < 6; k++) begin
      logic [5:0] op;
      case (k % 3)
        0: op = OP_MUL;
        1: op = OP_ADDI;
        default: op = 6'h01;
      endcase
      issue(op, 5'($urandom_range(1, 31)), 1'b1, 1'b0, $urandom, $urandom, $urandom,
            $urandom, 0, 0);
    end

    // load with 3-cycle ack
    ack_delay = 3;
    mem_rdata = 32'hCAFE;
    issue(OP_LOAD, 5'd9, 1'b1, 1'b0, 32'h0, 32'h0, 32'h100, 32'h0, 1, 3);

    // store with register_we set: no writeback
    ack_delay = 1;
    issue(OP_STORE, 5'd3, 1'b1, 1'b1, 32'hBEEF, 32'h0, 32'h200, 32'h0, 1, 1);

    // back-to-back: 1-cycle ack load, store, then ack on the last allowed cycle
    mem_rdata = 32'h55AA;
    issue(OP_LOAD, 5'd10, 1'b1, 1'b0, 32'h0, 32'h0, 32'h300, 32'h0, 1, 1);
    issue(OP_STORE, 5'd0, 1'b0, 1'b1, 32'h1357, 32'h0, 32'h304, 32'h0, 1, 1);
    ack_delay = 16;
    mem_rdata = 32'h1616;
    issue(OP_LOAD, 5'd11, 1'b1, 1'b0, 32'h0, 32'h0, 32'h308, 32'h0, 1, 16);
    chk("no_err_on_late_ack", 32'(bus.mem_error), 32'h0);

    // timeout: no ack ever
    mem_no_ack = 1'b1;
    issue(OP_LOAD, 5'd12, 1'b1, 1'b0, 32'h0, 32'h0, 32'h400, 32'h0, 2, 16);
    mem_no_ack = 1'b0;
    ack_delay = 1;
    issue(6'h00, 5'd13, 1'b1, 1'b0, 32'h0, 32'hA5A5, 32'h0, 32'h0, 0, 0);
    repeat (3) @(negedge clock);
    chk("err_sticky", 32'(bus.mem_error), 32'h1);

    // reset mid-WAIT
    @(posedge clock);
    #1;
    mem_no_ack = 1'b1;
    bus.opcode_d2      = OP_LOAD;
    bus.rd_d2          = 5'd14;
    bus.register_we_d2 = 1'b1;
    bus.sum_d2         = 32'h500;
    repeat (4) @(negedge clock);
    chk("midwait_req", 32'(bus.dmem_req), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_req", 32'(bus.dmem_req), 32'h0);
    chk("rst_async_stall", 32'(bus.stall), 32'h0);
    chk("rst_async_wb_we", 32'(bus.wb_we), 32'h0);
    chk("rst_async_err", 32'(bus.mem_error), 32'h0);
    bubble();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    mem_no_ack = 1'b0;
    @(negedge clock);
    bus.dmem_ack = 1'b1;
    @(negedge clock);
    chk("stray_ack_req", 32'(bus.dmem_req), 32'h0);
    chk("stray_ack_wb_we", 32'(bus.wb_we), 32'h0);
    chk("stray_ack_stall", 32'(bus.stall), 32'h0);
    @(posedge clock);
    #1;

    // rd==0 never written, then a normal op still works
    issue(6'h00, 5'd0, 1'b1, 1'b0, 32'h0, 32'hDEAD, 32'h0, 32'h0, 0, 0);
    @(negedge clock);
    chk("rd0_wb_we", 32'(bus.wb_we), 32'h0);
    @(posedge clock);
    #1;
    issue(6'h00, 5'd31, 1'b1, 1'b0, 32'h0, 32'h0F0F, 32'h0, 32'h0, 0, 0);
    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0t exp=finish", $time);
    $fatal(1);
  end

endmodule
